// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave sequencing controller.
// State encoding is also exported on the debug/display port.
package microwave_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/microwave_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Low i_en holds the count; i_restart forces it back to zero.
module microwave_ctrl_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en & ~i_restart & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Front-panel sequencer for the BCD countdown timer: keypad entry, cook/pause/done
// flow, 1 Hz decrement strobe, magnetron and beeper control. All outputs registered.
module microwave_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] key_digit,
    input  logic       key_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       zerado,
    output logic [3:0] t_data,
    output logic       t_load,
    output logic       t_en,
    output logic       t_clear,
    output logic       mag_on,
    output logic       beep,
    output logic [1:0] state
);

    import microwave_ctrl_pkg::*;

    localparam int unsigned BW = $clog2(BEEP_SECS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

    logic r_key_q, r_start_q, r_stop_q;
    logic w_key_rise, w_start_rise, w_stop_rise;
    logic w_key_load, w_cook_pause, w_idle_start;

    state_t r_state, w_next;

    logic          r_t_load, r_t_en, r_t_clear, r_mag_on, r_beep;
    logic [3:0]    r_t_data;
    logic          w_t_load, w_t_en, w_t_clear;
    logic [3:0]    w_t_data;
    logic [BW-1:0] r_beep_cnt, w_beep_cnt;

    logic w_pre_en, w_pre_restart, w_tick;

    assign w_key_rise   = key_valid & ~r_key_q;
    assign w_start_rise = start & ~r_start_q;
    assign w_stop_rise  = stop & ~r_stop_q;

    assign w_key_load   = w_key_rise & is_bcd(key_digit);
    assign w_cook_pause = w_stop_rise | ~door_closed;
    // In IDLE stop beats keypad beats start so at most one strobe/transition fires per cycle.
    assign w_idle_start = w_start_rise & door_closed & ~zerado & ~w_stop_rise & ~w_key_load;

    // Prescaler control is kept apart from next-state logic so the tick feeds forward only.
    always_comb begin
        w_pre_en      = 1'b0;
        w_pre_restart = 1'b0;
        case (r_state)
            ST_IDLE: w_pre_restart = w_idle_start;
            ST_COOK: begin
                w_pre_en      = ~w_cook_pause & ~zerado;
                w_pre_restart = ~w_cook_pause & zerado;
            end
            ST_DONE: w_pre_en = ~(w_stop_rise | w_key_rise);
            default: ;
        endcase
    end

    microwave_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (clear),
        .i_en      (w_pre_en),
        .i_restart (w_pre_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_next     = r_state;
        w_t_load   = 1'b0;
        w_t_en     = 1'b0;
        w_t_clear  = 1'b0;
        w_t_data   = r_t_data;
        w_beep_cnt = r_beep_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_stop_rise) begin
                    w_t_clear = 1'b1;
                end else if (w_key_load) begin
                    w_t_load = 1'b1;
                    w_t_data = key_digit;
                end else if (w_idle_start) begin
                    w_next = ST_COOK;
                end
            end
            ST_COOK: begin
                if (w_cook_pause) begin
                    w_next = ST_PAUSE;
                end else if (zerado) begin
                    w_next     = ST_DONE;
                    w_beep_cnt = '0;
                end else begin
                    w_t_en = w_tick;
                end
            end
            ST_PAUSE: begin
                if (w_stop_rise) begin
                    w_next    = ST_IDLE;
                    w_t_clear = 1'b1;
                end else if (w_start_rise && door_closed) begin
                    w_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (w_stop_rise || w_key_rise) begin
                    w_next     = ST_IDLE;
                    w_beep_cnt = '0;
                end else if (w_tick) begin
                    if (r_beep_cnt == BEEP_LAST) begin
                        w_next     = ST_IDLE;
                        w_beep_cnt = '0;
                    end else begin
                        w_beep_cnt = r_beep_cnt + 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_key_q    <= 1'b0;
            r_start_q  <= 1'b0;
            r_stop_q   <= 1'b0;
            r_t_load   <= 1'b0;
            r_t_en     <= 1'b0;
            r_t_clear  <= 1'b0;
            r_t_data   <= '0;
            r_mag_on   <= 1'b0;
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_key_q    <= key_valid;
            r_start_q  <= start;
            r_stop_q   <= stop;
            r_t_load   <= w_t_load;
            r_t_en     <= w_t_en;
            r_t_clear  <= w_t_clear;
            r_t_data   <= w_t_data;
            r_mag_on   <= (w_next == ST_COOK);
            r_beep     <= (w_next == ST_DONE);
            r_beep_cnt <= w_beep_cnt;
        end
    end

    assign t_data  = r_t_data;
    assign t_load  = r_t_load;
    assign t_en    = r_t_en;
    assign t_clear = r_t_clear;
    assign mag_on  = r_mag_on;
    assign beep    = r_beep;
    assign state   = r_state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench for microwave_ctrl driving a behavioural BCD timer (mn:sd:su).
// Stimulus pushes expected output events; the monitor pops them as the DUT emits them.
module tb_microwave_ctrl;

    localparam int EV_STATE = 0;
    localparam int EV_LOAD  = 1;
    localparam int EV_EN    = 2;
    localparam int EV_CLR   = 3;

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         gap;
    } ev_t;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] key_digit;
    logic       key_valid, start, stop, door_closed, zerado;
    logic [3:0] t_data;
    logic       t_load, t_en, t_clear, mag_on, beep;
    logic [1:0] state;

    logic [3:0] tm_mn = '0;
    logic [3:0] tm_sd = '0;
    logic [3:0] tm_su = '0;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    microwave_ctrl #(
        .TICK_DIV  (4),
        .BEEP_SECS (2)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .key_digit   (key_digit),
        .key_valid   (key_valid),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .zerado      (zerado),
        .t_data      (t_data),
        .t_load      (t_load),
        .t_en        (t_en),
        .t_clear     (t_clear),
        .mag_on      (mag_on),
        .beep        (beep),
        .state       (state)
    );

    always @(posedge clk) begin
        if (t_clear) begin
            tm_mn <= '0; tm_sd <= '0; tm_su <= '0;
        end else if (t_load) begin
            tm_mn <= tm_sd; tm_sd <= tm_su; tm_su <= t_data;
        end else if (t_en) begin
            if (tm_su != 0) begin
                tm_su <= tm_su - 4'd1;
            end else begin
                tm_su <= 4'd9;
                if (tm_sd != 0) begin
                    tm_sd <= tm_sd - 4'd1;
                end else begin
                    tm_sd <= 4'd5;
                    tm_mn <= (tm_mn == 0) ? 4'd9 : tm_mn - 4'd1;
                end
            end
        end
    end
    assign zerado = (tm_mn == 4'd0) && (tm_sd == 4'd0) && (tm_su == 4'd0);

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, req);
    endtask

    task automatic push(input int kind, input logic [3:0] val, input int gap);
        ev_t e;
        e.kind = kind; e.val = val; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d, input bit expect_load);
        if (expect_load) push(EV_LOAD, d, -1);
        key_digit = d; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        tick(1);
    endtask

    function automatic int timer_val();
        return int'({tm_mn, tm_sd, tm_su});
    endfunction

    // Monitor: every observed event must match the head of the expected queue.
    int         cyc = 0;
    int         last_cyc = 0;
    logic [3:0] prev = '0;

    task automatic observe(input int kind, input logic [3:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind=%0d val=%0h required none", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_val", int'(val), int'(e.val));
            if (e.gap >= 0) check("ev_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (clear) begin
            prev = '0;
        end else begin
            if ({state, mag_on, beep} != prev) begin
                prev = {state, mag_on, beep};
                observe(EV_STATE, prev);
            end
            if (t_load)  observe(EV_LOAD, t_data);
            if (t_en)    observe(EV_EN, 4'd0);
            if (t_clear) observe(EV_CLR, 4'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; key_digit = '0; key_valid = 1'b0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        tick(2);
        check("rst_state", int'(state), 0);
        check("rst_mag", int'(mag_on), 0);
        check("rst_beep", int'(beep), 0);
        check("rst_strobes", int'({t_load, t_en, t_clear}), 0);
        check("rst_data", int'(t_data), 0);
        clear = 1'b0;
        tick(2);

        // keypad entry 1,3,0
        key(4'd1, 1); key(4'd3, 1); key(4'd0, 1);
        tick(2);
        check("timer_130", timer_val(), 'h130);
        push(EV_CLR, 4'd0, -1);
        stop = 1'b1; tick(1); stop = 1'b0; tick(2);
        check("timer_clr", timer_val(), 'h000);
        key(4'd0, 1); key(4'd0, 1); key(4'd2, 1);
        tick(2);
        check("timer_002", timer_val(), 'h002);

        // cook 0:02 to completion, beep 8 clk, back to IDLE
        push(EV_STATE, 4'b0110, -1);
        push(EV_EN, 4'd0, 4);
        push(EV_EN, 4'd0, 4);
        push(EV_STATE, 4'b1101, 2);
        push(EV_STATE, 4'b0000, 8);
        start = 1'b1; tick(1); start = 1'b0;
        tick(25);
        check("timer_done", timer_val(), 'h000);

        // door opened mid-count, resume continues the held prescaler
        key(4'd0, 1); key(4'd0, 1); key(4'd5, 1);
        tick(1);
        check("timer_005", timer_val(), 'h005);
        push(EV_STATE, 4'b0110, -1);
        push(EV_EN, 4'd0, 4);
        push(EV_STATE, 4'b1000, 3);
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        door_closed = 1'b0;
        tick(5);
        check("timer_frozen", timer_val(), 'h004);
        push(EV_STATE, 4'b0110, 5);
        push(EV_EN, 4'd0, 2);
        door_closed = 1'b1; start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        push(EV_STATE, 4'b1000, 2);
        stop = 1'b1; tick(1); stop = 1'b0;

        // start and stop together in PAUSE: stop wins
        tick(2);
        push(EV_STATE, 4'b0000, 3);
        push(EV_CLR, 4'd0, 0);
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        tick(3);
        check("timer_cancel", timer_val(), 'h000);

        // ignored starts (zerado, door open) and a non-BCD key
        start = 1'b1; tick(1); start = 1'b0; tick(3);
        key(4'd1, 1);
        door_closed = 1'b0;
        start = 1'b1; tick(1); start = 1'b0; tick(3);
        key(4'd12, 0);
        door_closed = 1'b1;
        tick(2);
        check("idle_hold", int'(state), 0);
        check("timer_001", timer_val(), 'h001);

        // async clear mid-cook
        push(EV_STATE, 4'b0110, -1);
        start = 1'b1; tick(1); start = 1'b0; tick(1);
        clear = 1'b1;
        #1;
        check("clr_state", int'(state), 0);
        check("clr_mag", int'(mag_on), 0);
        check("clr_en", int'(t_en), 0);
        check("clr_beep", int'(beep), 0);
        tick(2);
        clear = 1'b0;
        tick(10);
        check("queue_empty", exp_q.size(), 0);
        check("timer_kept", timer_val(), 'h001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
